pm_host_driver: RTL and testbench
=================================

Name: pm_host_driver

Overview:
- Host-side counterpart of the processor top: accepts operand jobs from a host, drives the processor's operand, carry, enable and clear inputs, and collects the three 4-bit result registers.
- Per job it clears the processor, enables it for a fixed run window, samples r0..r2, and returns them to the host over a valid/ready result channel.
- Sits between a host stimulus source (test harness or switch/UART front end) and the processor top, one instance per processor.

Parameters:
- RUN_CYCLES, 8, cycles pm_en is held high per job; legal range 1..255.
- CLR_CYCLES, 1, cycles pm_clr is held high before the run window; legal range 1..15.
- SETTLE_CYCLES, 1, cycles between pm_en falling and result sampling; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- job_valid  in  1  host offers a job.
- job_ready  out  1  block accepts a job this cycle.
- job_a0, job_a1, job_a2  in  4 each  operands for m0, m1, m2.
- job_cin  in  1  carry-in for the job.
- pm_m0, pm_m1, pm_m2  out  4 each  operands to the processor.
- pm_cin  out  1  carry to the processor.
- pm_en  out  1  processor enable.
- pm_clr  out  1  processor clear (active-high).
- pm_r0, pm_r1, pm_r2  in  4 each  processor result registers.
- res_valid  out  1  result available.
- res_ready  in  1  host consumes the result.
- res_r0, res_r1, res_r2  out  4 each  captured results.
- job_count  out  8  number of completed jobs; wraps 255 -> 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous) sets the following and holds them until reset is released:
  - state=IDLE, job_ready=1.
  - pm_m0/m1/m2=0, pm_cin=0, pm_en=0, pm_clr=0.
  - res_valid=0, res_r0/r1/r2=0, job_count=0, busy=0.
- Reset asserted mid-job aborts the job immediately. No result is produced and job_count is not incremented.
- Job handshake:
  - job_ready=1 only in IDLE.
  - A job is accepted on the edge where job_valid & job_ready are both 1.
  - The operand registers load job_a0..a2 and job_cin on that edge and stay stable until the next accept.
- States and transitions:
  - IDLE: on accept -> CLEAR, and the phase counter loads CLR_CYCLES-1.
  - CLEAR: pm_clr=1, pm_en=0. When the counter reaches 0 -> RUN, and the counter loads RUN_CYCLES-1.
  - RUN: pm_clr=0, pm_en=1. When the counter reaches 0 -> SETTLE if SETTLE_CYCLES>0 (counter loads SETTLE_CYCLES-1), otherwise -> CAPTURE.
  - SETTLE: pm_en=0. When the counter reaches 0 -> CAPTURE.
  - CAPTURE (one cycle): res_r0..r2 <= pm_r0..r2, res_valid <= 1, job_count <= job_count+1 (8-bit wrap) -> HOLD.
  - HOLD: res_valid=1 and res_r* are stable. On res_valid & res_ready -> IDLE with res_valid=0 on the same edge.
- pm_clr and pm_en are registered outputs, never high together, and glitch-free.
- Latency, accept edge to res_valid high: CLR_CYCLES + RUN_CYCLES + SETTLE_CYCLES + 1 cycles.
- After a handshake, the next job cannot be accepted until the cycle after return to IDLE. Minimum job spacing = latency + 1 (res_ready already high) + 1.
- The host holding res_ready low stalls indefinitely in HOLD. The processor stays idle in that state (pm_en=0, pm_clr=0).
- job_valid outside IDLE is ignored; job_* inputs are not sampled.
- pm_r* are treated as stable at the CAPTURE edge; no synchronisation is done (same clock domain).

Test Plan:
- Reset values: assert reset low mid-cycle -> all outputs take their reset values immediately (asynchronous); release, then job_ready=1, busy=0.
- Single job, defaults: a0=3, a1=5, a2=9, cin=1, processor model returns r=(4,A,F). Required response:
  - pm_clr high for 1 cycle, then pm_en high for exactly 8 cycles, then 1 settle cycle.
  - res_valid rises 11 cycles after accept with res=(4,A,F) and job_count=1.
- Back-pressure: hold res_ready=0 for 20 cycles -> res_valid and res_r* stay constant and pm_en stays 0. Raise res_ready -> one handshake, then IDLE, job_ready=1 next cycle.
- Mid-job reset: reset during RUN at cycle 4 -> pm_en drops immediately, no res_valid, job_count stays 0. A fresh job afterward completes normally.
- Ignored offers and counter wrap, in one run:
  - job_valid held high while busy -> exactly one accept per job.
  - Run 256 back-to-back jobs -> job_count wraps to 0.
  - The ignored-offer check is repeated with SETTLE_CYCLES=0: latency drops to 10 cycles.

Source files
------------

// File: rtl/pm_host_driver_if.sv
// rtl/pm_host_driver_if.sv - host job/result channel between a stimulus source and pm_host_driver
interface pm_host_driver_if;
    logic       job_valid;
    logic       job_ready;
    logic [3:0] job_a0;
    logic [3:0] job_a1;
    logic [3:0] job_a2;
    logic       job_cin;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_r0;
    logic [3:0] res_r1;
    logic [3:0] res_r2;

    modport master (
        output job_valid, job_a0, job_a1, job_a2, job_cin, res_ready,
        input  job_ready, res_valid, res_r0, res_r1, res_r2
    );

    modport slave (
        input  job_valid, job_a0, job_a1, job_a2, job_cin, res_ready,
        output job_ready, res_valid, res_r0, res_r1, res_r2
    );
endinterface

// File: rtl/pm_host_driver.sv
// rtl/pm_host_driver.sv - runs one clear/enable/settle/capture sequence on the processor per host job
module pm_host_driver #(
    parameter int RUN_CYCLES    = 8,
    parameter int CLR_CYCLES    = 1,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    pm_host_driver_if.slave  host,
    output logic [3:0]       pm_m0,
    output logic [3:0]       pm_m1,
    output logic [3:0]       pm_m2,
    output logic             pm_cin,
    output logic             pm_en,
    output logic             pm_clr,
    input  logic [3:0]       pm_r0,
    input  logic [3:0]       pm_r1,
    input  logic [3:0]       pm_r2,
    output logic [7:0]       job_count,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        HOLD    = 3'd5
    } state_t;

    state_t     state;
    logic [7:0] phase_cnt;
    logic       job_ready_q;
    logic       res_valid_q;
    logic [3:0] res_r0_q;
    logic [3:0] res_r1_q;
    logic [3:0] res_r2_q;

    assign host.job_ready = job_ready_q;
    assign host.res_valid = res_valid_q;
    assign host.res_r0    = res_r0_q;
    assign host.res_r1    = res_r1_q;
    assign host.res_r2    = res_r2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            phase_cnt   <= 8'd0;
            job_ready_q <= 1'b1;
            pm_m0       <= 4'd0;
            pm_m1       <= 4'd0;
            pm_m2       <= 4'd0;
            pm_cin      <= 1'b0;
            pm_en       <= 1'b0;
            pm_clr      <= 1'b0;
            res_valid_q <= 1'b0;
            res_r0_q    <= 4'd0;
            res_r1_q    <= 4'd0;
            res_r2_q    <= 4'd0;
            job_count   <= 8'd0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (host.job_valid && job_ready_q) begin
                        pm_m0       <= host.job_a0;
                        pm_m1       <= host.job_a1;
                        pm_m2       <= host.job_a2;
                        pm_cin      <= host.job_cin;
                        pm_clr      <= 1'b1;
                        job_ready_q <= 1'b0;
                        busy        <= 1'b1;
                        phase_cnt   <= 8'(CLR_CYCLES - 1);
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (phase_cnt == 8'd0) begin
                        pm_clr    <= 1'b0;
                        pm_en     <= 1'b1;
                        phase_cnt <= 8'(RUN_CYCLES - 1);
                        state     <= RUN;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                RUN: begin
                    if (phase_cnt == 8'd0) begin
                        pm_en <= 1'b0;
                        // A zero settle window goes straight to sampling.
                        if (SETTLE_CYCLES > 0) begin
                            phase_cnt <= 8'(SETTLE_CYCLES - 1);
                            state     <= SETTLE;
                        end else begin
                            state <= CAPTURE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                SETTLE: begin
                    if (phase_cnt == 8'd0) begin
                        state <= CAPTURE;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                CAPTURE: begin
                    res_r0_q    <= pm_r0;
                    res_r1_q    <= pm_r1;
                    res_r2_q    <= pm_r2;
                    res_valid_q <= 1'b1;
                    job_count   <= job_count + 8'd1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (host.res_ready) begin
                        res_valid_q <= 1'b0;
                        job_ready_q <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    pm_en       <= 1'b0;
                    pm_clr      <= 1'b0;
                    res_valid_q <= 1'b0;
                    job_ready_q <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pm_host_driver.sv
// tb/tb_pm_host_driver.sv - directed self-checking bench for pm_host_driver
module tb_pm_host_driver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pm_host_driver_if h0();
    pm_host_driver_if h1();

    logic [3:0] d0_m0, d0_m1, d0_m2, d0_r0, d0_r1, d0_r2;
    logic       d0_cin, d0_en, d0_clr, d0_busy;
    logic [7:0] d0_jc;
    logic [3:0] d1_m0, d1_m1, d1_m2, d1_r0, d1_r1, d1_r2;
    logic       d1_cin, d1_en, d1_clr, d1_busy;
    logic [7:0] d1_jc;

    pm_host_driver u0 (
        .clk(clk), .reset(reset), .host(h0.slave),
        .pm_m0(d0_m0), .pm_m1(d0_m1), .pm_m2(d0_m2), .pm_cin(d0_cin),
        .pm_en(d0_en), .pm_clr(d0_clr),
        .pm_r0(d0_r0), .pm_r1(d0_r1), .pm_r2(d0_r2),
        .job_count(d0_jc), .busy(d0_busy)
    );

    pm_host_driver #(.SETTLE_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .host(h1.slave),
        .pm_m0(d1_m0), .pm_m1(d1_m1), .pm_m2(d1_m2), .pm_cin(d1_cin),
        .pm_en(d1_en), .pm_clr(d1_clr),
        .pm_r0(d1_r0), .pm_r1(d1_r1), .pm_r2(d1_r2),
        .job_count(d1_jc), .busy(d1_busy)
    );

    always @(posedge clk) begin
        if (d0_clr) begin
            d0_r0 <= 4'd0; d0_r1 <= 4'd0; d0_r2 <= 4'd0;
        end else if (d0_en) begin
            d0_r0 <= d0_m0 + {3'd0, d0_cin};
            d0_r1 <= d0_m1 + d0_m1;
            d0_r2 <= d0_m2 + d0_m1 + {3'd0, d0_cin};
        end
        if (d1_clr) begin
            d1_r0 <= 4'd0; d1_r1 <= 4'd0; d1_r2 <= 4'd0;
        end else if (d1_en) begin
            d1_r0 <= d1_m0 + {3'd0, d1_cin};
            d1_r1 <= d1_m1 + d1_m1;
            d1_r2 <= d1_m2 + d1_m1 + {3'd0, d1_cin};
        end
    end

    int en_cnt = 0, clr_cnt = 0, both_hi = 0;
    int acc0 = 0, hs0 = 0, acc1 = 0, hs1 = 0;

    always @(negedge clk) begin
        if (d0_en === 1'b1) en_cnt++;
        if (d0_clr === 1'b1) clr_cnt++;
        if ((d0_en === 1'b1 && d0_clr === 1'b1) || (d1_en === 1'b1 && d1_clr === 1'b1)) both_hi++;
    end

    always @(posedge clk) begin
        if (h0.job_valid === 1'b1 && h0.job_ready === 1'b1) acc0++;
        if (h0.res_valid === 1'b1 && h0.res_ready === 1'b1) hs0++;
        if (h1.job_valid === 1'b1 && h1.job_ready === 1'b1) acc1++;
        if (h1.res_valid === 1'b1 && h1.res_ready === 1'b1) hs1++;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cyc, b_en, b_clr, b_acc, b_hs, quiet;
        logic stable, got;
        logic [7:0] jc255;

        h0.job_valid = 0; h0.job_a0 = 0; h0.job_a1 = 0; h0.job_a2 = 0; h0.job_cin = 0; h0.res_ready = 0;
        h1.job_valid = 0; h1.job_a0 = 0; h1.job_a1 = 0; h1.job_a2 = 0; h1.job_cin = 0; h1.res_ready = 0;

        #2 reset = 0;
        #1;
        chk("rst_job_ready", h0.job_ready, 1'b1);
        chk("rst_busy", d0_busy, 1'b0);
        chk("rst_pm_en", d0_en, 1'b0);
        chk("rst_pm_clr", d0_clr, 1'b0);
        chk("rst_pm_m0", d0_m0, 4'd0);
        chk("rst_res_valid", h0.res_valid, 1'b0);
        chk("rst_res_r2", h0.res_r2, 4'd0);
        chk("rst_job_count", d0_jc, 8'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1;
        chk("rel_job_ready", h0.job_ready, 1'b1);
        chk("rel_busy", d0_busy, 1'b0);

        h0.job_valid = 1; h0.job_a0 = 4'h3; h0.job_a1 = 4'h5; h0.job_a2 = 4'h9; h0.job_cin = 1;
        b_en = en_cnt; b_clr = clr_cnt;
        @(posedge clk); #1 h0.job_valid = 0;
        chk("acc_pm_clr", d0_clr, 1'b1);
        chk("acc_pm_en", d0_en, 1'b0);
        chk("acc_job_ready", h0.job_ready, 1'b0);
        chk("acc_busy", d0_busy, 1'b1);
        chk("acc_pm_m2", d0_m2, 4'h9);
        cyc = 0;
        while (h0.res_valid !== 1'b1 && cyc < 40) begin @(posedge clk); #1 cyc++; end
        chk("j1_latency", cyc, 11);
        chk("j1_en_cycles", en_cnt - b_en, 8);
        chk("j1_clr_cycles", clr_cnt - b_clr, 1);
        chk("j1_res_r0", h0.res_r0, 4'h4);
        chk("j1_res_r1", h0.res_r1, 4'hA);
        chk("j1_res_r2", h0.res_r2, 4'hF);
        chk("j1_job_count", d0_jc, 8'd1);

        b_en = en_cnt; stable = 1;
        repeat (20) begin
            @(posedge clk); #1;
            if (h0.res_valid !== 1'b1 || h0.res_r0 !== 4'h4 || h0.res_r1 !== 4'hA || h0.res_r2 !== 4'hF || d0_en !== 1'b0 || d0_clr !== 1'b0) stable = 0;
        end
        chk("bp_stable", stable, 1'b1);
        chk("bp_no_en", en_cnt - b_en, 0);
        h0.res_ready = 1;
        @(posedge clk); #1;
        chk("hs_res_valid", h0.res_valid, 1'b0);
        chk("hs_job_ready", h0.job_ready, 1'b1);
        chk("hs_busy", d0_busy, 1'b0);

        h0.job_valid = 1; h0.job_a0 = 4'h1; h0.job_a1 = 4'h2; h0.job_a2 = 4'h3; h0.job_cin = 0;
        @(posedge clk); #1 h0.job_valid = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_in_run", d0_en, 1'b1);
        #2 reset = 0;
        #1;
        chk("mid_pm_en", d0_en, 1'b0);
        chk("mid_res_valid", h0.res_valid, 1'b0);
        chk("mid_job_count", d0_jc, 8'd0);
        chk("mid_job_ready", h0.job_ready, 1'b1);
        @(posedge clk); #1 reset = 1;
        quiet = 0;
        repeat (15) begin @(posedge clk); #1; if (h0.res_valid !== 1'b0) quiet++; end
        chk("mid_no_result", quiet, 0);
        h0.job_valid = 1;
        @(posedge clk); #1 h0.job_valid = 0;
        cyc = 0;
        while (h0.res_valid !== 1'b1 && cyc < 40) begin @(posedge clk); #1 cyc++; end
        chk("j2_latency", cyc, 11);
        chk("j2_res_r0", h0.res_r0, 4'h1);
        chk("j2_res_r1", h0.res_r1, 4'h4);
        chk("j2_res_r2", h0.res_r2, 4'h5);
        chk("j2_job_count", d0_jc, 8'd1);
        @(posedge clk); #1;

        reset = 0;
        @(posedge clk); #1 reset = 1;
        b_acc = acc0; b_hs = hs0; got = 0; jc255 = 8'd0;
        h0.job_valid = 1; h0.job_a0 = 4'h7; h0.job_a1 = 4'h1; h0.job_a2 = 4'h2; h0.job_cin = 0;
        cyc = 0;
        while (hs0 - b_hs < 256 && cyc < 5000) begin
            @(posedge clk); #1 cyc++;
            if (hs0 - b_hs == 255 && !got) begin jc255 = d0_jc; got = 1; end
        end
        h0.job_valid = 0;
        chk("wrap_cycles", cyc, 3328);
        chk("wrap_accepts", acc0 - b_acc, 256);
        chk("wrap_count_255", jc255, 8'hFF);
        chk("wrap_count_0", d0_jc, 8'd0);

        h1.res_ready = 1;
        h1.job_valid = 1; h1.job_a0 = 4'h3; h1.job_a1 = 4'h5; h1.job_a2 = 4'h9; h1.job_cin = 1;
        @(posedge clk); #1;
        chk("s0_pm_clr", d1_clr, 1'b1);
        cyc = 0;
        while (h1.res_valid !== 1'b1 && cyc < 40) begin @(posedge clk); #1 cyc++; end
        chk("s0_latency", cyc, 10);
        chk("s0_res_r0", h1.res_r0, 4'h4);
        chk("s0_res_r1", h1.res_r1, 4'hA);
        chk("s0_res_r2", h1.res_r2, 4'hF);
        while (hs1 < 3 && cyc < 200) begin @(posedge clk); #1 cyc++; end
        h1.job_valid = 0;
        chk("s0_three_jobs_cycles", cyc, 35);
        chk("s0_accepts", acc1, 3);
        chk("s0_job_count", d1_jc, 8'd3);
        chk("clr_en_exclusive", both_hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
